trng_packer: RTL and testbench
==============================

TRNG_PACKER -- requirements
Module: trng_packer

Interface
REQ-001 The block SHALL have parameter WORD_W, default 8, meaning the packed output word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of output FIFO entries (power of two, 2..16).
REQ-003 The block SHALL have parameter RCT_CUTOFF, default 32, meaning the repetition-count health-test limit (legal range 2..255).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, the asynchronous active-low reset.
REQ-006 The block SHALL have port i_valid, input, 1, high when a raw entropy bit is presented (driven by the TRNG o_valid).
REQ-007 The block SHALL have port i_bit, input, 1, the raw entropy bit (driven by the TRNG o_warbler), sampled only when i_valid=1.
REQ-008 The block SHALL have port i_clear, input, 1, a single-cycle request to clear the health failure and restart collection.
REQ-009 The block SHALL have port i_ready, input, 1, the consumer-ready signal for the output handshake.
REQ-010 The block SHALL have port o_valid, output, 1, high when o_data holds a valid packed word.
REQ-011 The block SHALL have port o_data, output, WORD_W, the FIFO head word.
REQ-012 The block SHALL have port o_level, output, clog2(DEPTH+1), the FIFO occupancy.
REQ-013 The block SHALL have port o_health_fail, output, 1, the sticky repetition-count failure flag.
REQ-014 The block SHALL have port o_overflow, output, 1, a sticky flag indicating a completed word was dropped because the FIFO was full.

Function
REQ-015 The block SHALL implement FSM states COLLECT and FAIL, and SHALL enter COLLECT on reset.
REQ-016 In COLLECT, each cycle with i_valid=1 SHALL accept i_bit into the assembly register, LSB-first: the first accepted bit lands at bit 0.
REQ-017 A 0..WORD_W-1 bit counter SHALL increment per accepted bit and wrap to 0 on the edge that accepts the WORD_W-th bit.
REQ-018 The completed word SHALL be written to the FIFO on that same edge, so with an empty FIFO o_valid=1 and o_data=word in the following cycle.
REQ-019 The output handshake SHALL be a pop on a cycle with o_valid=1 and i_ready=1; o_data SHALL hold stable while o_valid=1 and i_ready=0.
REQ-020 When the FIFO is full and no pop occurs, a completed word SHALL be dropped and o_overflow set; the bit counter still wraps to 0.
REQ-021 When the FIFO is full and a pop occurs on the same cycle, the push SHALL succeed, o_level SHALL remain DEPTH, and o_overflow SHALL NOT be set.
REQ-022 o_level SHALL be incremented on a push, decremented on a pop, and unchanged on a simultaneous push and pop.
REQ-023 The repetition counter SHALL load 1 on an accepted bit that differs from the previous accepted bit (or on the first accepted bit after reset or clear), and otherwise increment, saturating at RCT_CUTOFF.
REQ-024 When the repetition counter reaches RCT_CUTOFF, the block SHALL set o_health_fail, enter FAIL, and discard the partial word; the word completed on that same edge SHALL NOT be pushed.
REQ-025 In FAIL, the block SHALL ignore i_valid and i_bit, while FIFO words already stored SHALL remain poppable.
REQ-026 i_clear=1 SHALL, on the next edge in either state, clear o_health_fail and o_overflow, zero the bit counter, the assembly register and the repetition counter, and enter COLLECT; FIFO contents SHALL be kept.
REQ-027 i_clear SHALL take priority over a bit accepted on the same cycle, and that bit SHALL be discarded.

Reset
REQ-028 While rst=0, asynchronously: o_valid=0, o_data=0, o_level=0, o_health_fail=0, o_overflow=0, the FIFO pointers, bit counter, assembly register and repetition counter SHALL be 0, and the state SHALL be COLLECT.
REQ-029 Assertion of rst mid-word or mid-handshake SHALL discard all stored words and the partial word immediately.
REQ-030 After rst rises, the first i_valid=1 cycle SHALL be treated as the first accepted bit.

Verification
REQ-031 The bench SHALL cover this scenario: with WORD_W=8 and i_ready=1, feed bits 1,0,1,1,0,0,1,0 on every 5th cycle; o_data=8'h4D, o_valid pulses 1 cycle after the 8th bit, and o_level returns to 0.
REQ-032 The bench SHALL cover this scenario: with i_ready=0, feed 5 words of alternating bits (8'h55); o_level=4, o_overflow=1, and after i_ready=1 exactly 4 words of 8'h55 pop.
REQ-033 The bench SHALL cover this scenario: feed 32 consecutive 1 bits; o_health_fail=1 after the 32nd bit, only 3 words of 8'hFF are pushed, and further bits are ignored.
REQ-034 The bench SHALL cover this scenario: in FAIL, pulse i_clear then feed 8 alternating bits; o_health_fail=0 and one word of 8'h55 is produced.
REQ-035 The bench SHALL cover this scenario: with a full FIFO, pop and complete a word on the same cycle; o_level stays 4 and o_overflow stays 0.
REQ-036 The bench SHALL cover this scenario: drive rst=0 after 5 bits and 2 stored words; all outputs are 0 at once, and after release the next 8 bits form the first word.

Source files
------------

// File: rtl/trng_packer.sv
// trng_packer: packs raw TRNG bits LSB-first into WORD_W-bit words, runs a
// repetition-count health test on the raw stream, and buffers completed
// words in a small FIFO with a valid/ready output handshake.
module trng_packer #(
  parameter int WORD_W     = 8,
  parameter int DEPTH      = 4,
  parameter int RCT_CUTOFF = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  input  logic                         i_bit,
  input  logic                         i_clear,
  input  logic                         i_ready,
  output logic                         o_valid,
  output logic [WORD_W-1:0]            o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic                         o_health_fail,
  output logic                         o_overflow
);

  localparam int CW = $clog2(WORD_W);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  localparam logic [CW-1:0] LastBit   = CW'(WORD_W - 1);
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);
  localparam logic [LW-1:0] LevelOne  = LW'(1);
  localparam logic [PW-1:0] PtrOne    = PW'(1);
  localparam logic [7:0]    Cutoff    = 8'(RCT_CUTOFF);

  typedef enum logic {
    COLLECT = 1'b0,
    FAIL    = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [7:0]        rct_q, rct_d;
  logic              prev_q, prev_d;
  logic              fail_q, fail_d;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [WORD_W-1:0] mem_q [DEPTH];

  logic              pop;
  logic              accept;
  logic              complete;
  logic              trip;
  logic              push_req;
  logic              push;
  logic              drop;
  logic [7:0]        rct_next;
  logic [WORD_W-1:0] word;

  // Datapath decode: what the current bit does to the word, run counter and FIFO.
  always_comb begin
    word            = asm_q;
    word[bitcnt_q]  = i_bit;
    pop             = (level_q != '0) && i_ready;
    accept          = (state_q == COLLECT) && i_valid && !i_clear;
    complete        = accept && (bitcnt_q == LastBit);
    if ((rct_q == 8'd0) || (i_bit != prev_q)) begin
      rct_next = 8'd1;
    end else if (rct_q == Cutoff) begin
      rct_next = rct_q;
    end else begin
      rct_next = rct_q + 8'd1;
    end
    trip     = accept && (rct_next == Cutoff);
    push_req = complete && !trip;
    push     = push_req && ((level_q != LevelFull) || pop);
    drop     = push_req && (level_q == LevelFull) && !pop;
  end

  // Next-state for the collect/fail FSM, assembly, health test and FIFO pointers.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    asm_d    = asm_q;
    rct_d    = rct_q;
    prev_d   = prev_q;
    fail_d   = fail_q;
    ovf_d    = ovf_q;
    wptr_d   = push ? wptr_q + PtrOne : wptr_q;
    rptr_d   = pop  ? rptr_q + PtrOne : rptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + LevelOne;
    end else if (pop && !push) begin
      level_d = level_q - LevelOne;
    end

    if (i_clear) begin
      state_d  = COLLECT;
      fail_d   = 1'b0;
      ovf_d    = 1'b0;
      bitcnt_d = '0;
      asm_d    = '0;
      rct_d    = 8'd0;
      prev_d   = 1'b0;
    end else if (accept) begin
      prev_d = i_bit;
      rct_d  = rct_next;
      if (trip) begin
        state_d  = FAIL;
        fail_d   = 1'b1;
        bitcnt_d = '0;
        asm_d    = '0;
      end else if (complete) begin
        bitcnt_d = '0;
        asm_d    = '0;
        if (drop) begin
          ovf_d = 1'b1;
        end
      end else begin
        bitcnt_d = bitcnt_q + CW'(1);
        asm_d    = word;
      end
    end
  end

  // Control and status registers, cleared asynchronously by the low-active reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= COLLECT;
      bitcnt_q <= '0;
      asm_q    <= '0;
      rct_q    <= 8'd0;
      prev_q   <= 1'b0;
      fail_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      asm_q    <= asm_d;
      rct_q    <= rct_d;
      prev_q   <= prev_d;
      fail_q   <= fail_d;
      ovf_q    <= ovf_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
    end
  end

  // FIFO storage; contents are only visible while the level says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= word;
    end
  end

  assign o_valid       = (level_q != '0);
  assign o_data        = o_valid ? mem_q[rptr_q] : '0;
  assign o_level       = level_q;
  assign o_health_fail = fail_q;
  assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_trng_packer.sv
// Self-checking bench for trng_packer: directed scenarios followed by a
// random phase, all compared against a queue-based reference model.
module tb_trng_packer;

   localparam int W   = 8;
   localparam int D   = 4;
   localparam int CUT = 32;
   localparam int LW  = $clog2(D+1);

   logic          clk = 1'b0;
   logic          rst;
   logic          iValid;
   logic          iBit;
   logic          iClear;
   logic          iReady;
   logic          oValid;
   logic [W-1:0]  oData;
   logic [LW-1:0] oLevel;
   logic          oHealthFail;
   logic          oOverflow;

   int nVec = 0;
   int nErr = 0;
   int popSeen = 0;

   int   modelQ[$];
   int   partBits;
   int   partVal;
   int   runLen;
   logic lastBit;
   logic modelFail;
   logic modelOvf;

   logic [7:0] pat;

   trng_packer #(.WORD_W(W), .DEPTH(D), .RCT_CUTOFF(CUT)) dut (
      .clk(clk),
      .rst(rst),
      .i_valid(iValid),
      .i_bit(iBit),
      .i_clear(iClear),
      .i_ready(iReady),
      .o_valid(oValid),
      .o_data(oData),
      .o_level(oLevel),
      .o_health_fail(oHealthFail),
      .o_overflow(oOverflow)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Reference model reset: nothing stored, no partial word, no run history.
   task automatic modelReset();
      modelQ.delete();
      partBits  = 0;
      partVal   = 0;
      runLen    = 0;
      lastBit   = 1'b0;
      modelFail = 1'b0;
      modelOvf  = 1'b0;
   endtask

   // Reference model of one clock edge: pop first, then clear or accept a bit.
   task automatic modelEdge(input logic v, input logic b, input logic clr, input logic rdy);
      if (modelQ.size() > 0 && rdy) begin
         void'(modelQ.pop_front());
      end
      if (clr) begin
         modelFail = 1'b0;
         modelOvf  = 1'b0;
         partBits  = 0;
         partVal   = 0;
         runLen    = 0;
      end else if (v && !modelFail) begin
         if (runLen == 0 || b != lastBit) runLen = 1;
         else if (runLen < CUT) runLen = runLen + 1;
         lastBit = b;
         if (runLen == CUT) begin
            modelFail = 1'b1;
            partBits  = 0;
            partVal   = 0;
         end else begin
            partVal  = partVal + ((b ? 1 : 0) << partBits);
            partBits = partBits + 1;
            if (partBits == W) begin
               if (modelQ.size() < D) modelQ.push_back(partVal);
               else modelOvf = 1'b1;
               partBits = 0;
               partVal  = 0;
            end
         end
      end
   endtask

   // Single comparison point.
   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nErr++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every DUT output against the reference model.
   task automatic checkOutput();
      int expData;
      expData = (modelQ.size() > 0) ? modelQ[0] : 0;
      checkValue("valid",  32'(oValid),      32'(modelQ.size() > 0));
      checkValue("data",   32'(oData),       32'(expData));
      checkValue("level",  32'(oLevel),      32'(modelQ.size()));
      checkValue("health", 32'(oHealthFail), 32'(modelFail));
      checkValue("ovf",    32'(oOverflow),   32'(modelOvf));
   endtask

   // One clock: drive at the falling edge, model the rising edge, check at the next falling edge.
   task automatic applyStimulus(input logic v, input logic b, input logic clr, input logic rdy);
      iValid = v;
      iBit   = b;
      iClear = clr;
      iReady = rdy;
      if (oValid && rdy) popSeen++;
      @(posedge clk);
      modelEdge(v, b, clr, rdy);
      @(negedge clk);
      checkOutput();
   endtask

   // Directed scenarios followed by a randomized run.
   initial begin
      rst    = 1'b0;
      iValid = 1'b0;
      iBit   = 1'b0;
      iClear = 1'b0;
      iReady = 1'b0;
      modelReset();
      #3;
      checkOutput();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      $display("[TB] scenario: slow 8-bit word");
      pat = 8'h4D;
      for (int i = 0; i < 8; i++) begin
         repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
         applyStimulus(1'b1, pat[i], 1'b0, 1'b1);
      end
      checkValue("s1_data",  32'(oData),  32'h4D);
      checkValue("s1_valid", 32'(oValid), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkValue("s1_valid_after", 32'(oValid), 32'd0);
      checkValue("s1_level_after", 32'(oLevel), 32'd0);

      $display("[TB] scenario: overflow with consumer stalled");
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
         applyStimulus(1'b1, (i % 2) == 0, 1'b0, 1'b0);
      end
      checkValue("s2_level", 32'(oLevel),    32'd4);
      checkValue("s2_ovf",   32'(oOverflow), 32'd1);
      checkValue("s2_head",  32'(oData),     32'h55);
      popSeen = 0;
      repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkValue("s2_pops", 32'(popSeen), 32'd4);

      $display("[TB] scenario: repetition-count failure");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkValue("s3_ovf_cleared", 32'(oOverflow), 32'd0);
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
         if (i == 30) checkValue("s3_health_31", 32'(oHealthFail), 32'd0);
      end
      checkValue("s3_health", 32'(oHealthFail), 32'd1);
      checkValue("s3_level",  32'(oLevel),      32'd3);
      checkValue("s3_head",   32'(oData),       32'hFF);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, (i % 2) == 0, 1'b0, 1'b0);
      checkValue("s3_level_ignored", 32'(oLevel), 32'd3);

      $display("[TB] scenario: clear and restart");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkValue("s4_health", 32'(oHealthFail), 32'd0);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, (i % 2) == 0, 1'b0, 1'b0);
      checkValue("s4_level", 32'(oLevel), 32'd4);

      $display("[TB] scenario: push and pop on a full FIFO");
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, (i % 2) == 0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkValue("s5_level", 32'(oLevel),    32'd4);
      checkValue("s5_ovf",   32'(oOverflow), 32'd0);
      popSeen = 0;
      repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkValue("s5_pops",  32'(popSeen), 32'd4);
      checkValue("s5_empty", 32'(oLevel),  32'd0);

      $display("[TB] scenario: reset mid-word");
      for (int i = 0; i < 21; i++) applyStimulus(1'b1, (i % 2) == 0, 1'b0, 1'b0);
      checkValue("s6_level_before", 32'(oLevel), 32'd2);
      #2;
      rst = 1'b0;
      modelReset();
      #1;
      checkOutput();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, pat[i], 1'b0, 1'b0);
      checkValue("s6_data",  32'(oData),  32'h4D);
      checkValue("s6_level", 32'(oLevel), 32'd1);

      $display("[TB] random phase");
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 1) == 1,
                       $urandom_range(0, 7) != 0,
                       $urandom_range(0, 59) == 0,
                       $urandom_range(0, 3) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
